// File: rtl/bram1_frame_reader.sv
// Row-major reader for a 1-bit frame buffer: drives BRAM port B and emits a valid/ready pixel stream with x/y/eol/last.
// Optional macro FRAME_READER_LOOP_EN streams frames back to back after a single start.
module bram1_frame_reader #(
  parameter int IM_WIDTH   = 320,
  parameter int IM_HEIGHT  = 240,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic                  doutb,
  output logic                  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8:0]            out_x,
  output logic [7:0]            out_y,
  output logic                  out_eol,
  output logic                  out_last
);

  localparam logic [8:0] X_MAX = 9'(IM_WIDTH - 1);
  localparam logic [7:0] Y_MAX = 8'(IM_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  typedef struct packed {
    logic       data;
    logic [8:0] x;
    logic [7:0] y;
    logic       eol;
    logic       last;
  } pix_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [8:0]            r_x;
  logic [7:0]            r_y;
  logic                  r_pend_vld;
  logic [8:0]            r_pend_x;
  logic [7:0]            r_pend_y;
  logic                  r_pend_eol;
  logic                  r_pend_last;
  pix_t                  r_fifo [2];
  logic                  r_wp, r_rp;
  logic [1:0]            r_cnt;
  logic                  r_frame_done;

  logic                  w_last_addr;
  logic                  w_issue;
  logic                  w_start_acc;
  logic                  w_busy;
  logic                  w_pop;
  logic [2:0]            w_occ;
  pix_t                  w_head;
  pix_t                  w_wr_ent;

  assign w_last_addr = (r_x == X_MAX) && (r_y == Y_MAX);
  assign w_head      = r_fifo[r_rp];
  assign w_pop       = (r_cnt != 2'd0) && out_ready;
  // Occupancy seen by the next read counts this cycle's pop, so 1 pixel/cycle is sustainable with 2 entries
  assign w_occ       = {1'b0, r_cnt} + {2'b0, r_pend_vld} - {2'b0, w_pop};
  assign w_wr_ent    = '{data: doutb, x: r_pend_x, y: r_pend_y, eol: r_pend_eol, last: r_pend_last};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_READ;
      S_READ: begin
`ifdef FRAME_READER_LOOP_EN
        w_state_nxt = S_READ;
`else
        if (w_issue && w_last_addr) w_state_nxt = S_DRAIN;
`endif
      end
      S_DRAIN: if (w_pop && w_head.last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != S_IDLE);
    w_start_acc = (r_state == S_IDLE) && start;
    w_issue     = (r_state == S_READ) && (w_occ < 3'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_x    <= '0;
      r_y    <= '0;
    end else if (w_start_acc) begin
      r_addr <= '0;
      r_x    <= '0;
      r_y    <= '0;
    end else if (w_issue) begin
      if (!w_last_addr) begin
        r_addr <= r_addr + 1'b1;
        if (r_x == X_MAX) begin
          r_x <= '0;
          r_y <= r_y + 8'd1;
        end else begin
          r_x <= r_x + 9'd1;
        end
      end
`ifdef FRAME_READER_LOOP_EN
      else begin
        r_addr <= '0;
        r_x    <= '0;
        r_y    <= '0;
      end
`else
      else begin
        r_addr <= r_addr;
      end
`endif
    end
  end

  // Coordinates ride alongside the read through the BRAM latency cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_vld  <= 1'b0;
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      r_pend_eol  <= 1'b0;
      r_pend_last <= 1'b0;
    end else begin
      r_pend_vld <= w_issue;
      if (w_issue) begin
        r_pend_x    <= r_x;
        r_pend_y    <= r_y;
        r_pend_eol  <= (r_x == X_MAX);
        r_pend_last <= w_last_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo[0]    <= '0;
      r_fifo[1]    <= '0;
      r_wp         <= 1'b0;
      r_rp         <= 1'b0;
      r_cnt        <= 2'd0;
      r_frame_done <= 1'b0;
    end else begin
      if (r_pend_vld) begin
        r_fifo[r_wp] <= w_wr_ent;
        r_wp         <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt        <= r_cnt + {1'b0, r_pend_vld} - {1'b0, w_pop};
      r_frame_done <= w_pop && w_head.last;
    end
  end

  assign busy       = w_busy;
  assign frame_done = r_frame_done;
  assign addrb      = r_addr;
  assign out_valid  = (r_cnt != 2'd0);
  assign out_data   = w_head.data;
  assign out_x      = w_head.x;
  assign out_y      = w_head.y;
  assign out_eol    = w_head.eol;
  assign out_last   = w_head.last;

endmodule
